// File: rtl/display_7seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : display_7seg_scan_ctrl
//  Description : Digit-multiplexing scheduler for a 4-digit 7-segment display.
//                Walks the enabled digits in circular order. Each digit gets a
//                blanking gap (all selects off) followed by an on-window of
//                16 PWM slices. The digit select is asserted only for slices
//                0..brightness. The scheduled digit's nibble and dot are
//                forwarded so that segment decoding can happen downstream.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SLICE_CYCLES : clock cycles per PWM slice (on-window = 16*SLICE_CYCLES)
//    BLANK_CYCLES : all-off cycles before each on-window (must be >= 1)
//  Ports
//    clk          in   1   system clock
//    rst          in   1   synchronous active-high reset
//    nums         in  16   four nibbles, digit i = nums[4i+3:4i]
//    nums_enable  in   4   per-digit scan enable
//    dots_enable  in   4   per-digit dot enable
//    brightness   in   4   0 = 1/16 duty .. 15 = full on-window
//    hex_sel      out  4   active-low one-hot digit select (1111 = all off)
//    digit_idx    out  2   index of the scheduled digit
//    digit_val    out  4   nibble of the scheduled digit
//    dot          out  1   dot of the scheduled digit (active-high)
//    frame_tick   out  1   one-cycle pulse when the scan wraps around
// ============================================================================
module display_7seg_scan_ctrl #(
  parameter int SLICE_CYCLES = 3125,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] nums,
  input  logic [3:0]  nums_enable,
  input  logic [3:0]  dots_enable,
  input  logic [3:0]  brightness,
  output logic [3:0]  hex_sel,
  output logic [1:0]  digit_idx,
  output logic [3:0]  digit_val,
  output logic        dot,
  output logic        frame_tick
);

  // Counter widths are derived from the terminal counts so that the counters
  // never need to hold more than the last value of their range.
  localparam int SUB_W = (SLICE_CYCLES > 1) ? $clog2(SLICE_CYCLES) : 1;
  localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [SUB_W-1:0] C_SUB_LAST   = SUB_W'(SLICE_CYCLES - 1);
  localparam logic [BLK_W-1:0] C_BLK_LAST   = BLK_W'(BLANK_CYCLES - 1);
  localparam logic [3:0]       C_SLICE_LAST = 4'd15;
  localparam logic [3:0]       C_ALL_OFF    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and counters
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [SUB_W-1:0] r_sub_cnt;    // cycle within the current slice
  logic [3:0]       r_slice_cnt;  // slice within the on-window, 0..15
  logic [BLK_W-1:0] r_blank_cnt;  // cycle within the blanking gap

  // --------------------------------------------------------------------------
  // Next-value signals
  // --------------------------------------------------------------------------
  state_t           w_nxt_state;
  logic [1:0]       w_nxt_idx;
  logic [SUB_W-1:0] w_nxt_sub;
  logic [3:0]       w_nxt_slice;
  logic [BLK_W-1:0] w_nxt_blank;
  logic             w_nxt_tick;
  logic [3:0]       w_nxt_hex;
  logic [3:0]       w_nxt_val;
  logic             w_nxt_dot;

  logic [1:0]       w_lowest_idx;  // lowest enabled digit (scan start point)
  logic [1:0]       w_next_en_idx; // next enabled digit after digit_idx
  logic [1:0]       w_low_cand;
  logic [1:0]       w_next_cand;

  // Lowest set bit of nums_enable. Scanning from high to low lets the lowest
  // enabled index be the last assignment to win.
  always_comb begin
    w_lowest_idx = 2'd0;
    w_low_cand   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_low_cand = 2'(k);
      if (nums_enable[w_low_cand]) begin
        w_lowest_idx = w_low_cand;
      end
    end
  end

  // Circular search starting at digit_idx+1. Offsets are visited from the
  // farthest to the nearest so the nearest enabled digit wins. If none of the
  // other three digits is enabled, the current digit reselects itself; the
  // all-disabled case is handled separately by returning to IDLE.
  always_comb begin
    w_next_en_idx = digit_idx;
    w_next_cand   = digit_idx;
    for (int k = 3; k >= 1; k--) begin
      w_next_cand = digit_idx + 2'(k);
      if (nums_enable[w_next_cand]) begin
        w_next_en_idx = w_next_cand;
      end
    end
  end

  // Scheduler transition logic
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = digit_idx;
    w_nxt_sub   = r_sub_cnt;
    w_nxt_slice = r_slice_cnt;
    w_nxt_blank = r_blank_cnt;
    w_nxt_tick  = 1'b0;

    if (nums_enable == 4'b0000) begin
      // Nothing left to scan: park immediately, from any state, without
      // signalling a frame boundary.
      w_nxt_state = ST_IDLE;
      w_nxt_idx   = 2'd0;
      w_nxt_sub   = '0;
      w_nxt_slice = 4'd0;
      w_nxt_blank = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_nxt_state = ST_BLANK;
          w_nxt_idx   = w_lowest_idx;
          w_nxt_blank = '0;
        end

        ST_BLANK: begin
          if (r_blank_cnt == C_BLK_LAST) begin
            w_nxt_state = ST_ON;
            w_nxt_sub   = '0;
            w_nxt_slice = 4'd0;
          end else begin
            w_nxt_blank = r_blank_cnt + 1'b1;
          end
        end

        ST_ON: begin
          if (r_sub_cnt == C_SUB_LAST) begin
            w_nxt_sub = '0;
            if (r_slice_cnt == C_SLICE_LAST) begin
              // Last cycle of the on-window: hand over to the next digit.
              w_nxt_state = ST_BLANK;
              w_nxt_idx   = w_next_en_idx;
              w_nxt_blank = '0;
              w_nxt_tick  = (w_next_en_idx <= digit_idx);
            end else begin
              w_nxt_slice = r_slice_cnt + 4'd1;
            end
          end else begin
            w_nxt_sub = r_sub_cnt + 1'b1;
          end
        end

        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_idx   = 2'd0;
          w_nxt_sub   = '0;
          w_nxt_slice = 4'd0;
          w_nxt_blank = '0;
        end
      endcase
    end
  end

  // Output values are computed from the state being entered so that the
  // registered outputs describe the same cycle as the registered state.
  // The enable bit is checked live so a digit disabled mid-window goes dark
  // on the next cycle while its window keeps running.
  always_comb begin
    w_nxt_hex = C_ALL_OFF;
    w_nxt_val = 4'd0;
    w_nxt_dot = 1'b0;
    if (w_nxt_state != ST_IDLE) begin
      w_nxt_val = nums[{w_nxt_idx, 2'b00} +: 4];
      w_nxt_dot = dots_enable[w_nxt_idx];
      if ((w_nxt_state == ST_ON) && (w_nxt_slice <= brightness) &&
          nums_enable[w_nxt_idx]) begin
        w_nxt_hex = ~(4'b0001 << w_nxt_idx);
      end
    end
  end

  // --------------------------------------------------------------------------
  // State, counter and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sub_cnt   <= '0;
      r_slice_cnt <= 4'd0;
      r_blank_cnt <= '0;
      digit_idx   <= 2'd0;
      hex_sel     <= C_ALL_OFF;
      digit_val   <= 4'd0;
      dot         <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_sub_cnt   <= w_nxt_sub;
      r_slice_cnt <= w_nxt_slice;
      r_blank_cnt <= w_nxt_blank;
      digit_idx   <= w_nxt_idx;
      hex_sel     <= w_nxt_hex;
      digit_val   <= w_nxt_val;
      dot         <= w_nxt_dot;
      frame_tick  <= w_nxt_tick;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_7seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_7seg_scan_ctrl
//  Description : Directed self-checking bench for display_7seg_scan_ctrl with
//                SLICE_CYCLES=2 and BLANK_CYCLES=3 (digit period 35 cycles).
//                Expected output sequences are written out as segments of
//                (hex_sel, digit_idx, digit_val, dot, frame_tick, length).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_7seg_scan_ctrl;

  localparam int C_SLICE = 2;
  localparam int C_BLANK = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] nums = 16'h1234;
  logic [3:0]  nums_enable = 4'b0000;
  logic [3:0]  dots_enable = 4'b0100;
  logic [3:0]  brightness = 4'd15;
  logic [3:0]  hex_sel;
  logic [1:0]  digit_idx;
  logic [3:0]  digit_val;
  logic        dot;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  display_7seg_scan_ctrl #(
    .SLICE_CYCLES(C_SLICE),
    .BLANK_CYCLES(C_BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .nums       (nums),
    .nums_enable(nums_enable),
    .dots_enable(dots_enable),
    .brightness (brightness),
    .hex_sel    (hex_sel),
    .digit_idx  (digit_idx),
    .digit_val  (digit_val),
    .dot        (dot),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Check n consecutive cycles: hex_sel and frame_tick every cycle, the
  // scheduled digit's index/value/dot on the first cycle. frame_tick may only
  // be high on the first cycle of a segment.
  task automatic run_segment(input string tag, input logic [3:0] exp_hex,
                             input logic [1:0] exp_idx, input logic [3:0] exp_val,
                             input logic exp_dot, input logic exp_tick, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_hex[%0d]", tag, i), {28'd0, hex_sel}, {28'd0, exp_hex});
      check($sformatf("%s_tick[%0d]", tag, i), {31'd0, frame_tick},
            {31'd0, (i == 0) ? exp_tick : 1'b0});
      if (i == 0) begin
        check($sformatf("%s_idx", tag), {30'd0, digit_idx}, {30'd0, exp_idx});
        check($sformatf("%s_val", tag), {28'd0, digit_val}, {28'd0, exp_val});
        check($sformatf("%s_dot", tag), {31'd0, dot}, {31'd0, exp_dot});
      end
      tick(1);
    end
  endtask

  // One-cycle reset with new settings, check reset outputs, release, and
  // step into the first BLANK cycle.
  task automatic restart(input string tag, input logic [3:0] en, input logic [3:0] br);
    nums_enable = en;
    brightness  = br;
    rst = 1'b1;
    tick(1);
    check({tag, "_rst_hex"},  {28'd0, hex_sel},    32'hF);
    check({tag, "_rst_idx"},  {30'd0, digit_idx},  32'd0);
    check({tag, "_rst_val"},  {28'd0, digit_val},  32'd0);
    check({tag, "_rst_dot"},  {31'd0, dot},        32'd0);
    check({tag, "_rst_tick"}, {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    // 1: all digits, full brightness, digits 4,3,2,1; dot on digit 2 only
    restart("t1", 4'b1111, 4'd15);
    run_segment("t1b0",  4'b1111, 2'd0, 4'h4, 1'b0, 1'b0, 3);
    run_segment("t1on0", 4'b1110, 2'd0, 4'h4, 1'b0, 1'b0, 32);
    run_segment("t1b1",  4'b1111, 2'd1, 4'h3, 1'b0, 1'b0, 3);
    run_segment("t1on1", 4'b1101, 2'd1, 4'h3, 1'b0, 1'b0, 32);
    run_segment("t1b2",  4'b1111, 2'd2, 4'h2, 1'b1, 1'b0, 3);
    run_segment("t1on2", 4'b1011, 2'd2, 4'h2, 1'b1, 1'b0, 32);
    run_segment("t1b3",  4'b1111, 2'd3, 4'h1, 1'b0, 1'b0, 3);
    run_segment("t1on3", 4'b0111, 2'd3, 4'h1, 1'b0, 1'b0, 32);
    run_segment("t1b0x", 4'b1111, 2'd0, 4'h4, 1'b0, 1'b1, 3);
    run_segment("t1on0x",4'b1110, 2'd0, 4'h4, 1'b0, 1'b0, 32);

    // 2: digits 0 and 2, brightness 3 -> 8 cycles lit, 24 dark per window
    restart("t2", 4'b0101, 4'd3);
    run_segment("t2b0",   4'b1111, 2'd0, 4'h4, 1'b0, 1'b0, 3);
    run_segment("t2on0",  4'b1110, 2'd0, 4'h4, 1'b0, 1'b0, 8);
    run_segment("t2off0", 4'b1111, 2'd0, 4'h4, 1'b0, 1'b0, 24);
    run_segment("t2b2",   4'b1111, 2'd2, 4'h2, 1'b1, 1'b0, 3);
    run_segment("t2on2",  4'b1011, 2'd2, 4'h2, 1'b1, 1'b0, 8);
    run_segment("t2off2", 4'b1111, 2'd2, 4'h2, 1'b1, 1'b0, 24);
    run_segment("t2b0x",  4'b1111, 2'd0, 4'h4, 1'b0, 1'b1, 3);
    run_segment("t2on0x", 4'b1110, 2'd0, 4'h4, 1'b0, 1'b0, 8);

    // 3: single digit 3 reselects itself, frame_tick every 35 cycles
    restart("t3", 4'b1000, 4'd15);
    run_segment("t3b3",   4'b1111, 2'd3, 4'h1, 1'b0, 1'b0, 3);
    run_segment("t3on3",  4'b0111, 2'd3, 4'h1, 1'b0, 1'b0, 32);
    run_segment("t3b3x",  4'b1111, 2'd3, 4'h1, 1'b0, 1'b1, 3);
    run_segment("t3on3x", 4'b0111, 2'd3, 4'h1, 1'b0, 1'b0, 32);
    run_segment("t3b3y",  4'b1111, 2'd3, 4'h1, 1'b0, 1'b1, 3);

    // 4: digit 1 disabled mid-window; window completes, digit 1 skipped
    restart("t4", 4'b1111, 4'd15);
    run_segment("t4b0",   4'b1111, 2'd0, 4'h4, 1'b0, 1'b0, 3);
    run_segment("t4on0",  4'b1110, 2'd0, 4'h4, 1'b0, 1'b0, 32);
    run_segment("t4b1",   4'b1111, 2'd1, 4'h3, 1'b0, 1'b0, 3);
    run_segment("t4on1a", 4'b1101, 2'd1, 4'h3, 1'b0, 1'b0, 6);
    nums_enable = 4'b1101;
    run_segment("t4on1b", 4'b1101, 2'd1, 4'h3, 1'b0, 1'b0, 1);
    run_segment("t4on1c", 4'b1111, 2'd1, 4'h3, 1'b0, 1'b0, 25);
    run_segment("t4b2",   4'b1111, 2'd2, 4'h2, 1'b1, 1'b0, 3);
    run_segment("t4on2",  4'b1011, 2'd2, 4'h2, 1'b1, 1'b0, 32);
    run_segment("t4b3",   4'b1111, 2'd3, 4'h1, 1'b0, 1'b0, 3);
    run_segment("t4on3",  4'b0111, 2'd3, 4'h1, 1'b0, 1'b0, 32);
    run_segment("t4b0x",  4'b1111, 2'd0, 4'h4, 1'b0, 1'b1, 3);
    run_segment("t4on0x", 4'b1110, 2'd0, 4'h4, 1'b0, 1'b0, 32);
    run_segment("t4b2x",  4'b1111, 2'd2, 4'h2, 1'b1, 1'b0, 3);

    // 5: all enables cleared mid-window -> IDLE; re-enable digit 1
    run_segment("t5on2",  4'b1011, 2'd2, 4'h2, 1'b1, 1'b0, 10);
    nums_enable = 4'b0000;
    run_segment("t5on2l", 4'b1011, 2'd2, 4'h2, 1'b1, 1'b0, 1);
    run_segment("t5idle", 4'b1111, 2'd0, 4'h0, 1'b0, 1'b0, 2);
    nums_enable = 4'b0010;
    run_segment("t5idl2", 4'b1111, 2'd0, 4'h0, 1'b0, 1'b0, 1);
    run_segment("t5b1",   4'b1111, 2'd1, 4'h3, 1'b0, 1'b0, 3);
    run_segment("t5on1",  4'b1101, 2'd1, 4'h3, 1'b0, 1'b0, 32);
    run_segment("t5b1x",  4'b1111, 2'd1, 4'h3, 1'b0, 1'b1, 3);

    // 6: reset mid-window with all dots on; scan restarts with full BLANK
    dots_enable = 4'b1111;
    restart("t6a", 4'b1111, 4'd15);
    run_segment("t6b0",   4'b1111, 2'd0, 4'h4, 1'b1, 1'b0, 3);
    run_segment("t6on0",  4'b1110, 2'd0, 4'h4, 1'b1, 1'b0, 10);
    restart("t6b", 4'b1111, 4'd15);
    run_segment("t6b0r",  4'b1111, 2'd0, 4'h4, 1'b1, 1'b0, 3);
    run_segment("t6on0r", 4'b1110, 2'd0, 4'h4, 1'b1, 1'b0, 32);
    run_segment("t6b1r",  4'b1111, 2'd1, 4'h3, 1'b1, 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
